// File: rtl/handshake_constant_buf_if.sv
// Valid/ready bundle for handshake_constant_buf.
// Upstream control token in, constant data word out.
interface handshake_constant_buf_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ctrl_valid,
    output outs_ready,
    input  ctrl_ready,
    input  outs,
    input  outs_valid
  );

  modport slave (
    input  ctrl_valid,
    input  outs_ready,
    output ctrl_ready,
    output outs,
    output outs_valid
  );
endinterface

// File: rtl/handshake_constant_buf.sv
// Token buffer emitting a constant word; optional drain
// counter port enabled by HANDSHAKE_CONST_COUNT_EN.
module handshake_constant_buf #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [63:0] VALUE      = '0,
  parameter int          DEPTH      = 2
) (
  input logic clk,
  input logic rst,
  handshake_constant_buf_if.slave bus
`ifdef HANDSHAKE_CONST_COUNT_EN
  ,
  output logic [15:0] tokens_sent
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ONE  = OCC_W'(1);

  if (DEPTH < 1 || DEPTH > 16) begin : g_depth_chk
    $error("DEPTH out of range 1..16");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_dw_chk
    $error("DATA_WIDTH out of range 1..64");
  end

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             ready_q;
  logic             valid_q;
  logic             accept;
  logic             drain;

  assign accept = bus.ctrl_valid && ready_q;
  assign drain  = valid_q && bus.outs_ready;

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      accept && !drain: occ_d = occ_q + ONE;
      drain && !accept: occ_d = occ_q - ONE;
      default:          occ_d = occ_q;
    endcase
  end

  // Flags are registered from the next occupancy so neither
  // handshake output sees the opposite side combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= (occ_d != FULL);
      valid_q <= (occ_d != '0);
    end
  end

  assign bus.ctrl_ready = ready_q;
  assign bus.outs_valid = valid_q;
  assign bus.outs       = VALUE[DATA_WIDTH-1:0];

`ifdef HANDSHAKE_CONST_COUNT_EN
  logic [15:0] sent_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q <= '0;
    end else if (drain) begin
      sent_q <= sent_q + 16'd1;
    end
  end

  assign tokens_sent = sent_q;
`endif

endmodule
